// File: rtl/spi_xil_bram_in.sv
// SPI mode-0 slave receive path: synchronised SCLK/CS_N/MOSI are deserialised
// and written into a single-clock BRAM circular buffer drained by ren0/rdata0.
module spi_xil_bram_in #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clka0,
  input  logic              rstn,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  input  logic              ren0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  output logic              not_empty0,
  output logic [ADDR_W:0]   count0,
  output logic              overflow0,
  output logic              frame_done0,
  output logic [ADDR_W:0]   frame_len0
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BW    = $clog2(DATA_W);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_s, r_cs_s, r_mosi_s;
  logic                   r_sclk_d, r_cs_d;
  logic [SYNC_STAGES:0]   r_warm;
  state_t                 r_state, w_state_nxt;
  logic [DATA_W-1:0]      r_shift;
  logic [BW-1:0]          r_bit_cnt;
  logic [ADDR_W:0]        r_frame_cnt, r_count, r_frame_len;
  logic [ADDR_W-1:0]      r_waddr, r_raddr;
  logic [DATA_W-1:0]      r_mem [0:DEPTH-1];
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_rvalid, r_not_empty, r_overflow, r_frame_done;

  logic                   w_sclk, w_cs, w_mosi;
  logic                   w_sclk_rise, w_cs_fall, w_cs_rise;
  logic                   w_byte_rdy, w_frame_start, w_frame_end;
  logic                   w_full, w_rd, w_wr, w_drop;
  logic [DATA_W-1:0]      w_byte;
  logic [ADDR_W:0]        w_cnt_nxt, w_len_fin;

  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_cs        = r_cs_s[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;

  always_ff @(posedge clka0) begin
    if (!rstn) begin
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
      r_warm   <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], spi_sclk};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs;
      r_warm   <= {r_warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // The synchroniser resets to cs_n=1, so its output only reflects the pin once
  // r_warm has filled; without this gate a reset released mid-frame would look idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_IDLE: if (r_warm[SYNC_STAGES] && w_cs) w_state_nxt = IDLE;
      IDLE:      if (w_cs_fall) w_state_nxt = RECV;
      RECV:      if (w_cs_rise) w_state_nxt = IDLE;
      default:   w_state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clka0) begin
    if (!rstn) r_state <= WAIT_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_byte        = {r_shift[DATA_W-2:0], w_mosi};
  assign w_byte_rdy    = (r_state == RECV) && w_sclk_rise && (r_bit_cnt == BW'(DATA_W-1));
  assign w_frame_start = (r_state == IDLE) && w_cs_fall;
  assign w_frame_end   = (r_state == RECV) && w_cs_rise;

  // A full buffer still accepts a byte when a read frees a slot in the same cycle.
  assign w_full    = (r_count == FULL);
  assign w_rd      = ren0 && (r_count != '0);
  assign w_wr      = w_byte_rdy && (!w_full || w_rd);
  assign w_drop    = w_byte_rdy && w_full && !w_rd;
  assign w_cnt_nxt = r_count + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_rd);
  assign w_len_fin = (w_byte_rdy && r_frame_cnt != FULL) ? r_frame_cnt + (ADDR_W+1)'(1)
                                                         : r_frame_cnt;

  always_ff @(posedge clka0) begin
    if (w_wr) r_mem[r_waddr] <= w_byte;
  end

  always_ff @(posedge clka0) begin
    if (!rstn) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_frame_cnt  <= '0;
      r_frame_len  <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_waddr      <= '0;
      r_raddr      <= '0;
      r_count      <= '0;
      r_not_empty  <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_bit_cnt   <= '0;
        r_frame_cnt <= '0;
        r_overflow  <= 1'b0;
      end else if ((r_state == RECV) && w_sclk_rise) begin
        r_shift   <= w_byte;
        r_bit_cnt <= w_byte_rdy ? '0 : r_bit_cnt + BW'(1);
      end
      if (w_byte_rdy && r_frame_cnt != FULL) r_frame_cnt <= r_frame_cnt + (ADDR_W+1)'(1);
      if (w_drop) r_overflow <= 1'b1;
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_len <= w_len_fin;
      if (w_wr) r_waddr <= r_waddr + ADDR_W'(1);
      if (w_rd) begin
        r_raddr <= r_raddr + ADDR_W'(1);
        r_rdata <= r_mem[r_raddr];
      end
      r_rvalid    <= w_rd;
      r_count     <= w_cnt_nxt;
      r_not_empty <= (w_cnt_nxt != '0);
    end
  end

  assign rdata0      = r_rdata;
  assign rvalid0     = r_rvalid;
  assign not_empty0  = r_not_empty;
  assign count0      = r_count;
  assign overflow0   = r_overflow;
  assign frame_done0 = r_frame_done;
  assign frame_len0  = r_frame_len;
endmodule

// File: tb/tb_spi_xil_bram_in.sv
// Directed bench for spi_xil_bram_in, built with a 32-byte buffer so fill,
// overflow and wrap cases stay short.
module tb_spi_xil_bram_in;
  localparam int AW = 5;

  logic          clka0 = 1'b0, rstn = 1'b0;
  logic          spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0, ren0 = 1'b0;
  logic [7:0]    rdata0;
  logic          rvalid0, not_empty0, overflow0, frame_done0;
  logic [AW:0]   count0, frame_len0;

  int total = 0, bad = 0, n_done = 0, d0 = 0;
  bit in_t4 = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  always #5 clka0 = ~clka0;

  spi_xil_bram_in #(.ADDR_W(AW), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clka0(clka0), .rstn(rstn), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .ren0(ren0), .rdata0(rdata0), .rvalid0(rvalid0),
    .not_empty0(not_empty0), .count0(count0), .overflow0(overflow0),
    .frame_done0(frame_done0), .frame_len0(frame_len0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sclk = clka0/8: 4 cycles low, 4 cycles high per bit
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    send_bits(b, 8);
    if (keep) exp_q.push_back(b);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80 spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic drain(input int n);
    @(posedge clka0); #1 ren0 = 1'b1;
    repeat (n) @(posedge clka0);
    #1 ren0 = 1'b0;
    repeat (3) @(posedge clka0);
    #1;
  endtask

  always @(posedge clka0) if (frame_done0) n_done++;

  always @(negedge clka0) begin
    if (in_t4) chk("t4_count_le1", 32'(count0 <= 1), 1);
    if (rvalid0) begin
      chk("rd_q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_order", 32'(rdata0), 32'(e));
      end
    end
  end

  initial begin
    #3;
    repeat (3) @(posedge clka0);
    #1 chk("reset_outs", 32'({rdata0, rvalid0, not_empty0, count0, overflow0, frame_done0, frame_len0}), 0);
    rstn = 1'b1;
    #200;

    // 1: three-byte frame, back-to-back reads
    d0 = n_done;
    cs_low();
    send_byte(8'hA5, 1); send_byte(8'h3C, 1); send_byte(8'hFF, 1);
    cs_high();
    chk("t1_done_pulses", n_done - d0, 1);
    chk("t1_len", 32'(frame_len0), 3);
    chk("t1_count", 32'(count0), 3);
    chk("t1_ne", 32'(not_empty0), 1);
    @(posedge clka0); #1 ren0 = 1'b1;
    @(posedge clka0); #1 chk("t1_rv0", 32'(rvalid0), 1); chk("t1_d0", 32'(rdata0), 32'h A5);
    @(posedge clka0); #1 chk("t1_d1", 32'(rdata0), 32'h3C);
    @(posedge clka0); #1 chk("t1_d2", 32'(rdata0), 32'hFF);
    chk("t1_count0", 32'(count0), 0);
    chk("t1_ne0", 32'(not_empty0), 0);
    ren0 = 1'b0;
    @(posedge clka0); #1 chk("t1_rv_off", 32'(rvalid0), 0);
    chk("t1_hold", 32'(rdata0), 32'hFF);

    // 2: trailing partial byte is discarded
    cs_low();
    send_byte(8'h81, 1);
    send_bits(8'hA0, 4);
    cs_high();
    chk("t2_len", 32'(frame_len0), 1);
    chk("t2_count", 32'(count0), 1);
    drain(1);
    chk("t2_count_after", 32'(count0), 0);

    // 3: 34 bytes into 32 slots, frame length saturates at depth
    cs_low();
    for (int i = 0; i < 34; i++) send_byte(i[7:0], i < 32);
    cs_high();
    chk("t3_count_full", 32'(count0), 32);
    chk("t3_ovf", 32'(overflow0), 1);
    chk("t3_len_sat", 32'(frame_len0), 32);
    drain(32);
    chk("t3_count0", 32'(count0), 0);
    chk("t3_all_read", exp_q.size(), 0);
    chk("t3_ovf_sticky", 32'(overflow0), 1);
    cs_low();
    chk("t3_ovf_clr", 32'(overflow0), 0);
    cs_high();
    chk("t3_len_empty", 32'(frame_len0), 0);

    // 4: continuous ren0 while streaming
    ren0 = 1'b1;
    in_t4 = 1'b1;
    repeat (4) @(posedge clka0);
    #1 chk("t4_empty_rv", 32'(rvalid0), 0);
    cs_low();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 1);
    cs_high();
    ren0 = 1'b0;
    in_t4 = 1'b0;
    repeat (3) @(posedge clka0);
    #1 chk("t4_count", 32'(count0), 0);
    chk("t4_all_read", exp_q.size(), 0);

    // 5: pointer wrap (write pointer sits at 9 here, 28 bytes cross 31->0)
    cs_low();
    for (int i = 0; i < 28; i++) send_byte(8'(i * 7 + 3), 1);
    cs_high();
    chk("t5_count28", 32'(count0), 28);
    drain(28);
    cs_low();
    for (int i = 0; i < 10; i++) send_byte(8'(8'hC0 + i), 1);
    cs_high();
    chk("t5_count10", 32'(count0), 10);
    drain(10);
    chk("t5_all_read", exp_q.size(), 0);
    chk("t5_count0", 32'(count0), 0);

    // 6: reset mid-frame discards buffer and ignores the rest of that frame
    cs_low();
    send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);
    cs_high();
    chk("t6_pre_count", 32'(count0), 3);
    cs_low();
    send_bits(8'hB0, 4);
    rstn = 1'b0;
    @(posedge clka0); @(posedge clka0);
    #1 chk("t6_reset_outs", 32'({rdata0, rvalid0, not_empty0, count0, overflow0, frame_done0, frame_len0}), 0);
    exp_q.delete();
    rstn = 1'b1;
    d0 = n_done;
    send_byte(8'h77, 0); send_byte(8'h66, 0);
    chk("t6_ignored", 32'(count0), 0);
    cs_high();
    chk("t6_ignored_end", 32'(count0), 0);
    chk("t6_no_done", n_done - d0, 0);
    cs_low();
    send_byte(8'h5A, 1);
    cs_high();
    chk("t6_new_count", 32'(count0), 1);
    chk("t6_new_len", 32'(frame_len0), 1);
    chk("t6_new_done", n_done - d0, 1);
    drain(1);
    chk("t6_all_read", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
